bmd_256_latency_calc: RTL and testbench

- Read-side consumer of the latency timestamp BRAM, which the TX engine fills with send-time counter values indexed by echo sequence number.
- Each echo arrival reported by the RX engine triggers a BRAM read at the echo's tag. The block waits out the BRAM read latency, subtracts the stored send time from the arrival time and emits a per-packet latency.
- Maintains running statistics (count, min, max, sum) and a sequence-gap checker. Stats are read via VIO/ILA.

---
 rtl/bmd_256_latency_calc_if.sv | 36 +++
 rtl/bmd_256_latency_calc.sv | 185 ++++++++++++++++++
 tb/tb_bmd_256_latency_calc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmd_256_latency_calc_if.sv
// Bundle of the echo-input, BRAM port-B and result/statistics signals of
// bmd_256_latency_calc. The slave modport is the latency block's view; the
// master modport is the view of whatever drives it (RX engine, BRAM, VIO).
interface bmd_256_latency_calc_if #(
    parameter int COUNTER_WIDTH = 38,
    parameter int ADDR_WIDTH    = 13,
    parameter int SUM_WIDTH     = 64
);
    logic                     latency_reset_signal;
    logic [COUNTER_WIDTH-1:0] latency_counter;
    logic                     echo_valid;
    logic [ADDR_WIDTH-1:0]    echo_tag;
    logic                     bram_reb;
    logic [ADDR_WIDTH-1:0]    bram_rd_addr;
    logic [COUNTER_WIDTH-1:0] bram_rd_data;
    logic                     lat_valid;
    logic [COUNTER_WIDTH-1:0] lat_value;
    logic [ADDR_WIDTH-1:0]    lat_tag;
    logic [31:0]              stat_count;
    logic [COUNTER_WIDTH-1:0] stat_min;
    logic [COUNTER_WIDTH-1:0] stat_max;
    logic [SUM_WIDTH-1:0]     stat_sum;
    logic [15:0]              seq_err_count;

    modport slave (
        input  latency_reset_signal, latency_counter, echo_valid, echo_tag, bram_rd_data,
        output bram_reb, bram_rd_addr, lat_valid, lat_value, lat_tag,
               stat_count, stat_min, stat_max, stat_sum, seq_err_count
    );

    modport master (
        output latency_reset_signal, latency_counter, echo_valid, echo_tag, bram_rd_data,
        input  bram_reb, bram_rd_addr, lat_valid, lat_value, lat_tag,
               stat_count, stat_min, stat_max, stat_sum, seq_err_count
    );
endinterface

// File: rtl/bmd_256_latency_calc.sv
// Latency calculator: reads the send timestamp stored in the latency BRAM at
// each echo's tag, subtracts it from the arrival time, and keeps running
// count/min/max/sum statistics plus a sequence-gap counter.
// RD_LATENCY must lie in 1..4 to match the BRAM port-B read pipeline.
module bmd_256_latency_calc #(
    parameter int COUNTER_WIDTH = 38,
    parameter int ADDR_WIDTH    = 13,
    parameter int RD_LATENCY    = 2,
    parameter int SUM_WIDTH     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    bmd_256_latency_calc_if.slave  bus
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONES = {COUNTER_WIDTH{1'b1}};
    localparam logic [SUM_WIDTH-1:0]     SUM_ONES = {SUM_WIDTH{1'b1}};

    logic clear_s;
    logic accept_s;

    // Issue-side address hold
    logic [ADDR_WIDTH-1:0]    addr_hold_q, addr_hold_d;

    // Read-latency shadow pipeline (valid / tag / arrival time)
    logic [RD_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0]    pipe_tag_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_tag_d  [RD_LATENCY];
    logic [COUNTER_WIDTH-1:0] pipe_time_q [RD_LATENCY];
    logic [COUNTER_WIDTH-1:0] pipe_time_d [RD_LATENCY];

    // Per-packet result
    logic                     lat_valid_q, lat_valid_d;
    logic [COUNTER_WIDTH-1:0] lat_value_q, lat_value_d;
    logic [ADDR_WIDTH-1:0]    lat_tag_q,   lat_tag_d;

    // Statistics
    logic [31:0]              stat_count_q, stat_count_d;
    logic [COUNTER_WIDTH-1:0] stat_min_q,   stat_min_d;
    logic [COUNTER_WIDTH-1:0] stat_max_q,   stat_max_d;
    logic [SUM_WIDTH-1:0]     stat_sum_q,   stat_sum_d;
    logic [SUM_WIDTH:0]       sum_ext_s;

    // Sequence checker
    logic [ADDR_WIDTH-1:0]    expected_tag_q, expected_tag_d;
    logic                     first_pend_q,   first_pend_d;
    logic [15:0]              seq_err_q,      seq_err_d;

    assign clear_s  = bus.latency_reset_signal;
    // An echo arriving together with a clear is discarded entirely.
    assign accept_s = bus.echo_valid & ~clear_s;

    // BRAM port-B request: enable and address follow the echo in the same cycle.
    always_comb begin
        bus.bram_reb     = accept_s;
        bus.bram_rd_addr = addr_hold_q;
        addr_hold_d      = addr_hold_q;
        if (accept_s) begin
            bus.bram_rd_addr = bus.echo_tag;
            addr_hold_d      = bus.echo_tag;
        end else begin
            addr_hold_d      = addr_hold_q;
        end
    end

    // Shift tag and arrival time alongside the BRAM read; clear drops in-flight entries.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_tag_d     = pipe_tag_q;
        pipe_time_d    = pipe_time_q;
        pipe_vld_d[0]  = accept_s;
        pipe_tag_d[0]  = bus.echo_tag;
        pipe_time_d[0] = bus.latency_counter;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1] & ~clear_s;
            pipe_tag_d[i]  = pipe_tag_q[i-1];
            pipe_time_d[i] = pipe_time_q[i-1];
        end
    end

    // Compute the wraparound difference when the BRAM data lines up with the pipeline tail.
    always_comb begin
        lat_valid_d = pipe_vld_q[RD_LATENCY-1] & ~clear_s;
        lat_value_d = lat_value_q;
        lat_tag_d   = lat_tag_q;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            lat_value_d = pipe_time_q[RD_LATENCY-1] - bus.bram_rd_data;
            lat_tag_d   = pipe_tag_q[RD_LATENCY-1];
        end else begin
            lat_value_d = lat_value_q;
            lat_tag_d   = lat_tag_q;
        end
    end

    // Fold each registered result into the running statistics, saturating where needed.
    always_comb begin
        stat_count_d = stat_count_q;
        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        stat_sum_d   = stat_sum_q;
        sum_ext_s    = {1'b0, stat_sum_q} + {{(SUM_WIDTH+1-COUNTER_WIDTH){1'b0}}, lat_value_q};
        if (clear_s) begin
            stat_count_d = 32'd0;
            stat_min_d   = CNT_ONES;
            stat_max_d   = {COUNTER_WIDTH{1'b0}};
            stat_sum_d   = {SUM_WIDTH{1'b0}};
        end else if (lat_valid_q) begin
            stat_count_d = (stat_count_q == 32'hFFFF_FFFF) ? stat_count_q : stat_count_q + 32'd1;
            stat_sum_d   = sum_ext_s[SUM_WIDTH] ? SUM_ONES : sum_ext_s[SUM_WIDTH-1:0];
            stat_min_d   = (lat_value_q < stat_min_q) ? lat_value_q : stat_min_q;
            stat_max_d   = (lat_value_q > stat_max_q) ? lat_value_q : stat_max_q;
        end else begin
            stat_count_d = stat_count_q;
        end
    end

    // Sequence-gap checker: the first echo after reset/clear only seeds the expected tag.
    always_comb begin
        expected_tag_d = expected_tag_q;
        first_pend_d   = first_pend_q;
        seq_err_d      = seq_err_q;
        if (clear_s) begin
            expected_tag_d = {ADDR_WIDTH{1'b0}};
            first_pend_d   = 1'b1;
            seq_err_d      = 16'd0;
        end else if (accept_s) begin
            expected_tag_d = bus.echo_tag + ADDR_WIDTH'(1);
            first_pend_d   = 1'b0;
            if (!first_pend_q && (bus.echo_tag != expected_tag_q) && (seq_err_q != 16'hFFFF)) begin
                seq_err_d = seq_err_q + 16'd1;
            end else begin
                seq_err_d = seq_err_q;
            end
        end else begin
            expected_tag_d = expected_tag_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_q    <= {ADDR_WIDTH{1'b0}};
            pipe_vld_q     <= {RD_LATENCY{1'b0}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_tag_q[i]  <= {ADDR_WIDTH{1'b0}};
                pipe_time_q[i] <= {COUNTER_WIDTH{1'b0}};
            end
            lat_valid_q    <= 1'b0;
            lat_value_q    <= {COUNTER_WIDTH{1'b0}};
            lat_tag_q      <= {ADDR_WIDTH{1'b0}};
            stat_count_q   <= 32'd0;
            stat_min_q     <= CNT_ONES;
            stat_max_q     <= {COUNTER_WIDTH{1'b0}};
            stat_sum_q     <= {SUM_WIDTH{1'b0}};
            expected_tag_q <= {ADDR_WIDTH{1'b0}};
            first_pend_q   <= 1'b1;
            seq_err_q      <= 16'd0;
        end else begin
            addr_hold_q    <= addr_hold_d;
            pipe_vld_q     <= pipe_vld_d;
            pipe_tag_q     <= pipe_tag_d;
            pipe_time_q    <= pipe_time_d;
            lat_valid_q    <= lat_valid_d;
            lat_value_q    <= lat_value_d;
            lat_tag_q      <= lat_tag_d;
            stat_count_q   <= stat_count_d;
            stat_min_q     <= stat_min_d;
            stat_max_q     <= stat_max_d;
            stat_sum_q     <= stat_sum_d;
            expected_tag_q <= expected_tag_d;
            first_pend_q   <= first_pend_d;
            seq_err_q      <= seq_err_d;
        end
    end

    assign bus.lat_valid     = lat_valid_q;
    assign bus.lat_value     = lat_value_q;
    assign bus.lat_tag       = lat_tag_q;
    assign bus.stat_count    = stat_count_q;
    assign bus.stat_min      = stat_min_q;
    assign bus.stat_max      = stat_max_q;
    assign bus.stat_sum      = stat_sum_q;
    assign bus.seq_err_count = seq_err_q;

endmodule

// File: tb/tb_bmd_256_latency_calc.sv
// Directed bench for bmd_256_latency_calc with a behavioural 2-cycle BRAM.
module tb_bmd_256_latency_calc;

    localparam int CW = 38;
    localparam int AW = 13;
    localparam int SW = 64;
    localparam int RL = 2;
    localparam logic [CW-1:0] ONES = {CW{1'b1}};

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    bmd_256_latency_calc_if #(.COUNTER_WIDTH(CW), .ADDR_WIDTH(AW), .SUM_WIDTH(SW)) bus ();

    bmd_256_latency_calc #(.COUNTER_WIDTH(CW), .ADDR_WIDTH(AW), .RD_LATENCY(RL), .SUM_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM port B: two-register read pipeline, output register reset by rstb.
    logic [CW-1:0] mem [8192];
    logic [CW-1:0] rd_p1;
    always @(posedge clk) begin
        if (bus.latency_reset_signal) begin
            rd_p1            <= '0;
            bus.bram_rd_data <= '0;
        end else begin
            if (bus.bram_reb) rd_p1 <= mem[bus.bram_rd_addr];
            bus.bram_rd_data <= rd_p1;
        end
    end

    // Result monitor: log every lat_valid pulse with its cycle number.
    logic [CW-1:0] q_val [$];
    logic [AW-1:0] q_tag [$];
    int            q_cyc [$];
    always @(negedge clk) begin
        if (bus.lat_valid === 1'b1) begin
            q_val.push_back(bus.lat_value);
            q_tag.push_back(bus.lat_tag);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        tick();
        bus.latency_reset_signal = 1'b1;
        tick();
        bus.latency_reset_signal = 1'b0;
    endtask

    task automatic flush_log();
        q_val.delete();
        q_tag.delete();
        q_cyc.delete();
    endtask

    typedef struct {
        logic [AW-1:0] tag;
        logic [CW-1:0] stored;
        logic [CW-1:0] arrival;
        logic [CW-1:0] exp_lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int issue_cyc;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;

        vecs[0] = '{tag: 13'd5,    stored: 38'd100,          arrival: 38'd350,          exp_lat: 38'd250};
        vecs[1] = '{tag: 13'd0,    stored: 38'h3F_FFFF_FFF6, arrival: 38'd20,           exp_lat: 38'd30};
        vecs[2] = '{tag: 13'd100,  stored: 38'd0,            arrival: 38'd0,            exp_lat: 38'd0};
        vecs[3] = '{tag: 13'd8191, stored: 38'd1000,         arrival: 38'd999,          exp_lat: 38'h3F_FFFF_FFFF};
        vecs[4] = '{tag: 13'd7,    stored: 38'h1F_FFFF_FFFF, arrival: 38'h3F_FFFF_FFFF, exp_lat: 38'h20_0000_0000};

        rst = 1'b1;
        bus.latency_reset_signal = 1'b0;
        bus.latency_counter      = '0;
        bus.echo_valid           = 1'b0;
        bus.echo_tag             = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lat_valid", 64'(bus.lat_valid), 64'd0);
        chk("rst_stat_min",  64'(bus.stat_min), 64'(ONES));
        chk("rst_stat_cnt",  64'(bus.stat_count), 64'd0);
        chk("rst_seq_err",   64'(bus.seq_err_count), 64'd0);
        chk("rst_rd_addr",   64'(bus.bram_rd_addr), 64'd0);
        rst = 1'b0;

        // Table: isolated single echoes
        foreach (vecs[i]) begin
            do_clear();
            flush_log();
            mem[vecs[i].tag] = vecs[i].stored;
            tick();
            bus.echo_valid      = 1'b1;
            bus.echo_tag        = vecs[i].tag;
            bus.latency_counter = vecs[i].arrival;
            issue_cyc           = cyc;
            #1;
            chk("issue_reb",  64'(bus.bram_reb), 64'd1);
            chk("issue_addr", 64'(bus.bram_rd_addr), 64'(vecs[i].tag));
            tick();
            bus.echo_valid = 1'b0;
            #1;
            chk("idle_reb",       64'(bus.bram_reb), 64'd0);
            chk("idle_addr_hold", 64'(bus.bram_rd_addr), 64'(vecs[i].tag));
            repeat (6) tick();
            chk("vec_pulses", 64'(q_val.size()), 64'd1);
            if (q_val.size() == 1) begin
                chk("vec_latency_cyc", 64'(q_cyc[0] - issue_cyc), 64'(RL + 1));
                chk("vec_value",       64'(q_val[0]), 64'(vecs[i].exp_lat));
                chk("vec_tag",         64'(q_tag[0]), 64'(vecs[i].tag));
            end
            chk("vec_cnt", 64'(bus.stat_count), 64'd1);
            chk("vec_min", 64'(bus.stat_min), 64'(vecs[i].exp_lat));
            chk("vec_max", 64'(bus.stat_max), 64'(vecs[i].exp_lat));
            chk("vec_sum", 64'(bus.stat_sum), 64'(vecs[i].exp_lat));
        end

        // Back-to-back tags 0..3, stored 0, arrivals 10..13
        do_clear();
        flush_log();
        for (int j = 0; j < 4; j++) mem[j] = '0;
        tick();
        issue_cyc = cyc;
        for (int j = 0; j < 4; j++) begin
            bus.echo_valid      = 1'b1;
            bus.echo_tag        = 13'(j);
            bus.latency_counter = 38'(10 + j);
            tick();
        end
        bus.echo_valid = 1'b0;
        repeat (6) tick();
        chk("b2b_pulses", 64'(q_val.size()), 64'd4);
        if (q_val.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("b2b_value", 64'(q_val[j]), 64'(10 + j));
                chk("b2b_tag",   64'(q_tag[j]), 64'(j));
                chk("b2b_cyc",   64'(q_cyc[j] - issue_cyc), 64'(RL + 1 + j));
            end
        end
        chk("b2b_cnt", 64'(bus.stat_count), 64'd4);
        chk("b2b_min", 64'(bus.stat_min), 64'd10);
        chk("b2b_max", 64'(bus.stat_max), 64'd13);
        chk("b2b_sum", 64'(bus.stat_sum), 64'd46);
        chk("b2b_seq", 64'(bus.seq_err_count), 64'd0);

        // Sequence gaps: 0,1,3,8191,0 -> two errors
        do_clear();
        flush_log();
        tick();
        foreach (vecs[i]) begin
            bus.echo_valid = 1'b1;
            case (i)
                0:       bus.echo_tag = 13'd0;
                1:       bus.echo_tag = 13'd1;
                2:       bus.echo_tag = 13'd3;
                3:       bus.echo_tag = 13'd8191;
                default: bus.echo_tag = 13'd0;
            endcase
            tick();
        end
        bus.echo_valid = 1'b0;
        repeat (6) tick();
        chk("seq_err", 64'(bus.seq_err_count), 64'd2);
        chk("seq_cnt", 64'(bus.stat_count), 64'd5);

        // Clear one cycle after issue, with an echo colliding with the clear
        do_clear();
        flush_log();
        mem[10] = 38'd5;
        mem[20] = 38'd1;
        tick();
        bus.echo_valid      = 1'b1;
        bus.echo_tag        = 13'd10;
        bus.latency_counter = 38'd100;
        tick();
        bus.echo_tag             = 13'd20;
        bus.latency_reset_signal = 1'b1;
        #1;
        chk("clr_reb_forced", 64'(bus.bram_reb), 64'd0);
        tick();
        bus.echo_valid           = 1'b0;
        bus.latency_reset_signal = 1'b0;
        repeat (6) tick();
        chk("clr_no_pulse", 64'(q_val.size()), 64'd0);
        chk("clr_cnt",      64'(bus.stat_count), 64'd0);
        chk("clr_min",      64'(bus.stat_min), 64'(ONES));
        mem[500] = 38'd0;
        bus.echo_valid      = 1'b1;
        bus.echo_tag        = 13'd500;
        bus.latency_counter = 38'd42;
        tick();
        bus.echo_valid = 1'b0;
        repeat (6) tick();
        chk("clr_resume_seq", 64'(bus.seq_err_count), 64'd0);
        chk("clr_resume_cnt", 64'(bus.stat_count), 64'd1);
        chk("clr_resume_val", 64'(bus.stat_max), 64'd42);

        // Asynchronous reset in the middle of a stream and mid-cycle
        do_clear();
        for (int j = 0; j < 3; j++) mem[j] = '0;
        tick();
        for (int j = 0; j < 3; j++) begin
            bus.echo_valid      = 1'b1;
            bus.echo_tag        = 13'(j);
            bus.latency_counter = 38'(50 + j);
            tick();
        end
        bus.echo_valid = 1'b0;
        tick();
        chk("pre_rst_cnt", 64'(bus.stat_count), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_lat_valid", 64'(bus.lat_valid), 64'd0);
        chk("arst_lat_value", 64'(bus.lat_value), 64'd0);
        chk("arst_lat_tag",   64'(bus.lat_tag), 64'd0);
        chk("arst_cnt",       64'(bus.stat_count), 64'd0);
        chk("arst_min",       64'(bus.stat_min), 64'(ONES));
        chk("arst_max",       64'(bus.stat_max), 64'd0);
        chk("arst_sum",       64'(bus.stat_sum), 64'd0);
        chk("arst_rd_addr",   64'(bus.bram_rd_addr), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("arst_no_pulse_cnt", 64'(bus.stat_count), 64'd0);
        flush_log();
        mem[77] = 38'd3;
        bus.echo_valid      = 1'b1;
        bus.echo_tag        = 13'd77;
        bus.latency_counter = 38'd10;
        tick();
        bus.echo_valid = 1'b0;
        repeat (6) tick();
        chk("arst_resume_pulses", 64'(q_val.size()), 64'd1);
        if (q_val.size() == 1) chk("arst_resume_val", 64'(q_val[0]), 64'd7);
        chk("arst_resume_seq", 64'(bus.seq_err_count), 64'd0);
        chk("arst_resume_cnt", 64'(bus.stat_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
